// File: rtl/menu_pkg.sv
// Shared definitions for the menu selection generator: pixel/count widths,
// default blanking colour, navigation FSM encoding and index-width helper.
package menu_pkg;

  localparam int RGB_W = 12;
  localparam int CNT_W = 11;

  localparam logic [RGB_W-1:0] BLANK_COLOR_DEF = 12'h333;

  typedef enum logic [0:0] {
    NAV     = 1'b0,
    CONFIRM = 1'b1
  } nav_state_e;

  // Width of a box index; a single box still needs one bit of cursor.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/menu_nav_fsm.sv
// Menu navigation: button edge detection, pending flags, frame-synchronous
// cursor movement and the valid/ready hand-off of the confirmed option.
module menu_nav_fsm
  import menu_pkg::*;
#(
  parameter int   NUM_BOXES = 4,
  parameter bit   WRAP      = 1'b1,
  localparam int  IDX_W     = idx_width(NUM_BOXES)
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             vblnk_i,
  input  logic             btn_up_i,
  input  logic             btn_down_i,
  input  logic             btn_enter_i,
  input  logic             sel_ready_i,
  output logic [IDX_W-1:0] cursor_o,
  output logic             sel_valid_o,
  output logic [IDX_W-1:0] sel_idx_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BOXES - 1);

  nav_state_e       state_q;
  logic [IDX_W-1:0] cursor_q;
  logic [IDX_W-1:0] cursor_d;
  logic [IDX_W-1:0] sel_idx_q;
  logic             sel_valid_q;
  logic             up_hist_q;
  logic             dn_hist_q;
  logic             en_hist_q;
  logic             vblnk_hist_q;
  logic             pend_up_q;
  logic             pend_dn_q;
  logic             pend_en_q;
  logic             pend_up_d;
  logic             pend_dn_d;
  logic             pend_en_d;
  logic             frame_tick;

  // A rising edge in the current cycle counts together with what is already pending.
  assign pend_up_d  = pend_up_q | (btn_up_i    & ~up_hist_q);
  assign pend_dn_d  = pend_dn_q | (btn_down_i  & ~dn_hist_q);
  assign pend_en_d  = pend_en_q | (btn_enter_i & ~en_hist_q);
  assign frame_tick = vblnk_i & ~vblnk_hist_q;

  // Cursor target for this frame tick; conflicting up+down requests cancel.
  // With a single box both end rules collapse to index 0.
  always_comb begin
    cursor_d = cursor_q;
    if (pend_up_d && !pend_dn_d) begin
      if (cursor_q == IDX_W'(0)) begin
        cursor_d = WRAP ? LAST_IDX : IDX_W'(0);
      end else begin
        cursor_d = cursor_q - IDX_W'(1);
      end
    end else if (pend_dn_d && !pend_up_d) begin
      if (cursor_q == LAST_IDX) begin
        cursor_d = WRAP ? IDX_W'(0) : cursor_q;
      end else begin
        cursor_d = cursor_q + IDX_W'(1);
      end
    end else begin
      cursor_d = cursor_q;
    end
  end

  // Navigation / confirm state machine with registered cursor and handshake.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= NAV;
      cursor_q     <= IDX_W'(0);
      sel_idx_q    <= IDX_W'(0);
      sel_valid_q  <= 1'b0;
      up_hist_q    <= 1'b0;
      dn_hist_q    <= 1'b0;
      en_hist_q    <= 1'b0;
      vblnk_hist_q <= 1'b0;
      pend_up_q    <= 1'b0;
      pend_dn_q    <= 1'b0;
      pend_en_q    <= 1'b0;
    end else begin
      // History always follows the buttons so a held button never re-triggers.
      up_hist_q    <= btn_up_i;
      dn_hist_q    <= btn_down_i;
      en_hist_q    <= btn_enter_i;
      vblnk_hist_q <= vblnk_i;
      case (state_q)
        NAV: begin
          if (frame_tick) begin
            cursor_q  <= cursor_d;
            pend_up_q <= 1'b0;
            pend_dn_q <= 1'b0;
            pend_en_q <= 1'b0;
            if (pend_en_d) begin
              state_q     <= CONFIRM;
              sel_valid_q <= 1'b1;
              sel_idx_q   <= cursor_d;
            end
          end else begin
            pend_up_q <= pend_up_d;
            pend_dn_q <= pend_dn_d;
            pend_en_q <= pend_en_d;
          end
        end
        CONFIRM: begin
          // Presses while an option is on offer are dropped, not queued.
          pend_up_q <= 1'b0;
          pend_dn_q <= 1'b0;
          pend_en_q <= 1'b0;
          if (sel_valid_q && sel_ready_i) begin
            sel_valid_q <= 1'b0;
            state_q     <= NAV;
          end
        end
        default: begin
          state_q     <= NAV;
          sel_valid_q <= 1'b0;
          pend_up_q   <= 1'b0;
          pend_dn_q   <= 1'b0;
          pend_en_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cursor_o    = cursor_q;
  assign sel_valid_o = sel_valid_q;
  assign sel_idx_o   = sel_idx_q;

endmodule

// File: rtl/menu_select_gen.sv
// Menu background generator: screen frame plus NUM_BOXES stacked option
// boxes with cursor highlight, in a two-stage pixel pipeline. Navigation and
// the selection handshake are delegated to menu_nav_fsm.
module menu_select_gen
  import menu_pkg::*;
#(
  parameter int               NUM_BOXES   = 4,
  parameter int               BOX_X0      = 362,
  parameter int               BOX_X1      = 674,
  parameter int               BOX_Y0      = 46,
  parameter int               BOX_H       = 100,
  parameter int               BOX_PITCH   = 192,
  parameter int               H_LAST      = 1023,
  parameter int               V_LAST      = 767,
  parameter logic [RGB_W-1:0] BLANK_COLOR = BLANK_COLOR_DEF,
  parameter bit               WRAP        = 1'b1,
  parameter bit               FILL_SEL    = 1'b1,
  localparam int              IDX_W       = idx_width(NUM_BOXES)
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] vcount_in,
  input  logic [CNT_W-1:0] hcount_in,
  input  logic             vsync_in,
  input  logic             hsync_in,
  input  logic             vblnk_in,
  input  logic             hblnk_in,
  input  logic [RGB_W-1:0] color_bg,
  input  logic [RGB_W-1:0] color_frame,
  input  logic [RGB_W-1:0] color_hl,
  input  logic [RGB_W-1:0] color_fill,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_enter,
  input  logic             sel_ready,
  output logic [CNT_W-1:0] vcount_out,
  output logic [CNT_W-1:0] hcount_out,
  output logic             vsync_out,
  output logic             hsync_out,
  output logic             vblnk_out,
  output logic             hblnk_out,
  output logic [RGB_W-1:0] rgb_out,
  output logic [IDX_W-1:0] cursor,
  output logic             sel_valid,
  output logic [IDX_W-1:0] sel_idx
);

  localparam logic [CNT_W-1:0] X0 = CNT_W'(BOX_X0);
  localparam logic [CNT_W-1:0] X1 = CNT_W'(BOX_X1);

  logic [NUM_BOXES-1:0] box_edge_s;
  logic [NUM_BOXES-1:0] box_in_s;
  logic                 in_x_s;
  logic                 on_x_s;
  logic                 strict_x_s;

  // Columns are shared by every box, so the horizontal test is computed once.
  assign in_x_s     = (hcount_in >= X0) && (hcount_in <= X1);
  assign on_x_s     = (hcount_in == X0) || (hcount_in == X1);
  assign strict_x_s = (hcount_in > X0) && (hcount_in < X1);

  // Row bounds of each box are elaboration constants; no runtime multiply.
  for (genvar k = 0; k < NUM_BOXES; k++) begin : g_box
    localparam logic [CNT_W-1:0] TOP = CNT_W'(BOX_Y0 + k * BOX_PITCH);
    localparam logic [CNT_W-1:0] BOT = CNT_W'(BOX_Y0 + k * BOX_PITCH + BOX_H);
    logic in_y_s;
    logic on_y_s;
    logic strict_y_s;
    assign in_y_s        = (vcount_in >= TOP) && (vcount_in <= BOT);
    assign on_y_s        = (vcount_in == TOP) || (vcount_in == BOT);
    assign strict_y_s    = (vcount_in > TOP) && (vcount_in < BOT);
    assign box_edge_s[k] = in_x_s && in_y_s && (on_x_s || on_y_s);
    assign box_in_s[k]   = strict_x_s && strict_y_s;
  end

  // Stage 1 registers
  logic [CNT_W-1:0]     vcount_q;
  logic [CNT_W-1:0]     hcount_q;
  logic                 vsync_q;
  logic                 hsync_q;
  logic                 vblnk_q;
  logic                 hblnk_q;
  logic [NUM_BOXES-1:0] box_edge_q;
  logic [NUM_BOXES-1:0] box_in_q;
  logic [RGB_W-1:0]     col_bg_q;
  logic [RGB_W-1:0]     col_frame_q;
  logic [RGB_W-1:0]     col_hl_q;
  logic [RGB_W-1:0]     col_fill_q;

  // Stage 1: capture timing, counts, colours and per-box hit flags.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vcount_q    <= CNT_W'(0);
      hcount_q    <= CNT_W'(0);
      vsync_q     <= 1'b0;
      hsync_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      hblnk_q     <= 1'b0;
      box_edge_q  <= NUM_BOXES'(0);
      box_in_q    <= NUM_BOXES'(0);
      col_bg_q    <= RGB_W'(0);
      col_frame_q <= RGB_W'(0);
      col_hl_q    <= RGB_W'(0);
      col_fill_q  <= RGB_W'(0);
    end else begin
      vcount_q    <= vcount_in;
      hcount_q    <= hcount_in;
      vsync_q     <= vsync_in;
      hsync_q     <= hsync_in;
      vblnk_q     <= vblnk_in;
      hblnk_q     <= hblnk_in;
      box_edge_q  <= box_edge_s;
      box_in_q    <= box_in_s;
      col_bg_q    <= color_bg;
      col_frame_q <= color_frame;
      col_hl_q    <= color_hl;
      col_fill_q  <= color_fill;
    end
  end

  logic [IDX_W-1:0]     cursor_s;
  logic [NUM_BOXES-1:0] sel_mask;
  logic                 frame_hit;
  logic                 hl_hit;
  logic                 any_edge;
  logic                 fill_hit;
  logic [RGB_W-1:0]     rgb_d;

  // One-hot decode of the cursor to match it against the per-box flags.
  always_comb begin
    sel_mask = NUM_BOXES'(0);
    for (int k = 0; k < NUM_BOXES; k++) begin
      sel_mask[k] = (cursor_s == IDX_W'(k));
    end
  end

  assign frame_hit = (vcount_q == CNT_W'(0)) || (vcount_q == CNT_W'(V_LAST)) ||
                     (hcount_q == CNT_W'(1)) || (hcount_q == CNT_W'(H_LAST));
  assign hl_hit    = |(box_edge_q & sel_mask);
  assign any_edge  = |box_edge_q;
  assign fill_hit  = |(box_in_q & sel_mask);

  // Stage 2 colour priority: blanking, frame, selected edge, other edge, fill, background.
  always_comb begin
    rgb_d = col_bg_q;
    if (vblnk_q || hblnk_q) begin
      rgb_d = BLANK_COLOR;
    end else if (frame_hit) begin
      rgb_d = col_frame_q;
    end else if (hl_hit) begin
      rgb_d = col_hl_q;
    end else if (any_edge) begin
      rgb_d = col_frame_q;
    end else if (fill_hit && FILL_SEL) begin
      rgb_d = col_fill_q;
    end else begin
      rgb_d = col_bg_q;
    end
  end

  // Stage 2: registered video outputs.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vcount_out <= CNT_W'(0);
      hcount_out <= CNT_W'(0);
      vsync_out  <= 1'b0;
      hsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      rgb_out    <= RGB_W'(0);
    end else begin
      vcount_out <= vcount_q;
      hcount_out <= hcount_q;
      vsync_out  <= vsync_q;
      hsync_out  <= hsync_q;
      vblnk_out  <= vblnk_q;
      hblnk_out  <= hblnk_q;
      rgb_out    <= rgb_d;
    end
  end

  menu_nav_fsm #(
    .NUM_BOXES (NUM_BOXES),
    .WRAP      (WRAP)
  ) u_nav (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .vblnk_i     (vblnk_in),
    .btn_up_i    (btn_up),
    .btn_down_i  (btn_down),
    .btn_enter_i (btn_enter),
    .sel_ready_i (sel_ready),
    .cursor_o    (cursor_s),
    .sel_valid_o (sel_valid),
    .sel_idx_o   (sel_idx)
  );

  assign cursor = cursor_s;

endmodule

// File: tb/tb_menu_select_gen.sv
// Self-checking bench for menu_select_gen: a wrapping and a saturating
// instance share all inputs and are compared against a behavioural model.
module tb_menu_select_gen;

  localparam int NB = 4, X0 = 362, X1 = 674, Y0 = 46, BH = 100, PITCH = 192;
  localparam int HL = 1023, VL = 767;
  localparam logic [11:0] BLANK = 12'h333;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] vcount_in = 11'd0, hcount_in = 11'd0;
  logic        vsync_in = 1'b0, hsync_in = 1'b0, vblnk_in = 1'b0, hblnk_in = 1'b0;
  logic [11:0] c_bg = 12'h0A5, c_frame = 12'hFFF, c_hl = 12'hF00, c_fill = 12'h0F0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_enter = 1'b0, sel_ready = 1'b0;

  logic [10:0] vc_o [2];
  logic [10:0] hc_o [2];
  logic        vs_o [2];
  logic        hs_o [2];
  logic        vb_o [2];
  logic        hb_o [2];
  logic [11:0] rgb_o [2];
  logic [1:0]  cur_o [2];
  logic        sv_o [2];
  logic [1:0]  si_o [2];

  always #5 pclk = ~pclk;

  // Instance 0 wraps at the ends, instance 1 saturates.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    menu_select_gen #(.WRAP((g == 0) ? 1'b1 : 1'b0)) u_dut (
      .pclk(pclk), .rst_n(rst_n),
      .vcount_in(vcount_in), .hcount_in(hcount_in),
      .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
      .color_bg(c_bg), .color_frame(c_frame), .color_hl(c_hl), .color_fill(c_fill),
      .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter), .sel_ready(sel_ready),
      .vcount_out(vc_o[g]), .hcount_out(hc_o[g]),
      .vsync_out(vs_o[g]), .hsync_out(hs_o[g]), .vblnk_out(vb_o[g]), .hblnk_out(hb_o[g]),
      .rgb_out(rgb_o[g]), .cursor(cur_o[g]), .sel_valid(sv_o[g]), .sel_idx(si_o[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [11:0] rgb0;
    logic [11:0] rgb1;
    logic [10:0] vc;
    logic [10:0] hc;
    logic [3:0]  tim;
  } exp_t;

  exp_t sbq [$];
  int   m_cur [2];
  int   m_idx [2];
  bit   m_conf, m_pu, m_pd, m_pe, h_up, h_dn, h_en, h_vb;

  // Colour of one pixel from the screen layout rules.
  function automatic logic [11:0] ref_pixel(input int h, input int v, input bit blank, input int cur);
    bit hl = 1'b0, ed = 1'b0, fl = 1'b0;
    if (blank) return BLANK;
    if (v == 0 || v == VL || h == 1 || h == HL) return c_frame;
    for (int k = 0; k < NB; k++) begin
      int top = Y0 + k * PITCH;
      int bot = top + BH;
      if (h >= X0 && h <= X1 && v >= top && v <= bot) begin
        if (h == X0 || h == X1 || v == top || v == bot) begin
          if (k == cur) hl = 1'b1; else ed = 1'b1;
        end else if (k == cur) begin
          fl = 1'b1;
        end
      end
    end
    if (hl) return c_hl;
    if (ed) return c_frame;
    if (fl) return c_fill;
    return c_bg;
  endfunction

  function automatic int move(input int c, input bit up, input bit wrap);
    if (up) return wrap ? (c + NB - 1) % NB : ((c > 0) ? c - 1 : 0);
    return wrap ? (c + 1) % NB : ((c < NB - 1) ? c + 1 : c);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin m_cur[i] = 0; m_idx[i] = 0; end
    {m_conf, m_pu, m_pd, m_pe, h_up, h_dn, h_en, h_vb} = '0;
    sbq.delete();
    sbq.push_back('0);
  endtask

  // Advance the model by one clock using the inputs present at that edge.
  task automatic model_step();
    bit tick;
    tick = vblnk_in && !h_vb;
    if (m_conf) begin
      {m_pu, m_pd, m_pe} = 3'b000;
      if (sel_ready) m_conf = 1'b0;
    end else begin
      m_pu = m_pu || (btn_up && !h_up);
      m_pd = m_pd || (btn_down && !h_dn);
      m_pe = m_pe || (btn_enter && !h_en);
      if (tick) begin
        for (int i = 0; i < 2; i++) begin
          if (m_pu != m_pd) m_cur[i] = move(m_cur[i], m_pu, (i == 0));
        end
        if (m_pe) begin
          m_conf = 1'b1;
          for (int i = 0; i < 2; i++) m_idx[i] = m_cur[i];
        end
        {m_pu, m_pd, m_pe} = 3'b000;
      end
    end
    h_up = btn_up; h_dn = btn_down; h_en = btn_enter; h_vb = vblnk_in;
  endtask

  // One clock: queue the expected pixel, clock, then compare every output.
  task automatic cycle();
    exp_t e;
    e.rgb0 = ref_pixel(hcount_in, vcount_in, vblnk_in || hblnk_in, m_cur[0]);
    e.rgb1 = ref_pixel(hcount_in, vcount_in, vblnk_in || hblnk_in, m_cur[1]);
    e.vc   = vcount_in;
    e.hc   = hcount_in;
    e.tim  = {vsync_in, hsync_in, vblnk_in, hblnk_in};
    sbq.push_back(e);
    @(posedge pclk);
    model_step();
    #1;
    e = sbq.pop_front();
    chk("rgb_wrap", rgb_o[0], e.rgb0);
    chk("rgb_sat", rgb_o[1], e.rgb1);
    chk("vcount", vc_o[0], e.vc);
    chk("hcount", hc_o[1], e.hc);
    chk("timing", {vs_o[0], hs_o[0], vb_o[0], hb_o[0]}, e.tim);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("cursor%0d", i), cur_o[i], m_cur[i]);
      chk($sformatf("sel_valid%0d", i), sv_o[i], m_conf);
      chk($sformatf("sel_idx%0d", i), si_o[i], m_idx[i]);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_rgb"}, rgb_o[i], 0);
      chk({tag, "_cnt"}, {vc_o[i], hc_o[i]}, 0);
      chk({tag, "_tim"}, {vs_o[i], hs_o[i], vb_o[i], hb_o[i]}, 0);
      chk({tag, "_sel"}, {cur_o[i], sv_o[i], si_o[i]}, 0);
    end
  endtask

  task automatic set_px(input int h, input int v);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
  endtask

  // Buttons given as {up, down, enter}: held two cycles, then released.
  task automatic press(input logic [2:0] b);
    {btn_up, btn_down, btn_enter} = b;
    cycle(); cycle();
    {btn_up, btn_down, btn_enter} = 3'b000;
    cycle();
  endtask

  task automatic frame_tick();
    vblnk_in = 1'b0; cycle();
    vblnk_in = 1'b1; cycle();
    vblnk_in = 1'b0; cycle();
  endtask

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        vb;
    logic        hb;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl [17];
  int   hset [12] = '{0, 1, 2, 361, 362, 363, 500, 673, 674, 675, 1022, 1023};
  int   vset [16] = '{0, 45, 46, 47, 145, 146, 147, 237, 238, 239, 430, 431, 622, 623, 766, 767};

  initial begin
    // Layout vectors, cursor on box 0.
    tbl[0]  = '{11'd362,  11'd46,  1'b0, 1'b0, c_hl};
    tbl[1]  = '{11'd362,  11'd238, 1'b0, 1'b0, c_frame};
    tbl[2]  = '{11'd500,  11'd100, 1'b0, 1'b0, c_fill};
    tbl[3]  = '{11'd500,  11'd200, 1'b0, 1'b0, c_bg};
    tbl[4]  = '{11'd500,  11'd100, 1'b1, 1'b0, BLANK};
    tbl[5]  = '{11'd500,  11'd100, 1'b0, 1'b1, BLANK};
    tbl[6]  = '{11'd1,    11'd400, 1'b0, 1'b0, c_frame};
    tbl[7]  = '{11'd1023, 11'd400, 1'b0, 1'b0, c_frame};
    tbl[8]  = '{11'd0,    11'd400, 1'b0, 1'b0, c_bg};
    tbl[9]  = '{11'd674,  11'd146, 1'b0, 1'b0, c_hl};
    tbl[10] = '{11'd363,  11'd47,  1'b0, 1'b0, c_fill};
    tbl[11] = '{11'd361,  11'd46,  1'b0, 1'b0, c_bg};
    tbl[12] = '{11'd500,  11'd0,   1'b0, 1'b0, c_frame};
    tbl[13] = '{11'd500,  11'd767, 1'b0, 1'b0, c_frame};
    tbl[14] = '{11'd500,  11'd431, 1'b0, 1'b0, c_bg};
    tbl[15] = '{11'd675,  11'd100, 1'b0, 1'b0, c_bg};
    tbl[16] = '{11'd500,  11'd146, 1'b0, 1'b0, c_hl};

    // Reset state
    model_reset();
    #22;
    chk_zero("reset");
    @(posedge pclk); #1;
    rst_n = 1'b1;

    // Table-driven pixel checks; the result of vector i appears after vector i+1's edge.
    for (int i = 0; i <= 17; i++) begin
      if (i < 17) begin
        set_px(tbl[i].h, tbl[i].v);
        vblnk_in = tbl[i].vb;
        hblnk_in = tbl[i].hb;
      end else begin
        set_px(500, 300); vblnk_in = 1'b0; hblnk_in = 1'b0;
      end
      cycle();
      if (i >= 1) chk($sformatf("tbl%0d", i - 1), rgb_o[0], tbl[i - 1].exp);
    end

    // Down mid-frame: cursor waits for the next vblnk rise.
    set_px(500, 300);
    press(3'b010);
    repeat (5) cycle();
    chk("down_wait", cur_o[0], 0);
    frame_tick();
    chk("down_tick_w", cur_o[0], 1);
    chk("down_tick_s", cur_o[1], 1);
    set_px(362, 238); cycle(); cycle();
    chk("box1_hl", rgb_o[0], c_hl);
    set_px(362, 46); cycle(); cycle();
    chk("box0_frame", rgb_o[0], c_frame);

    // Up at index 0: wrap to 3 versus stay at 0.
    press(3'b100); frame_tick();
    chk("up_to0", cur_o[0], 0);
    press(3'b100); frame_tick();
    chk("up_wrap", cur_o[0], 3);
    chk("up_sat", cur_o[1], 0);
    repeat (3) begin press(3'b010); frame_tick(); end
    chk("down3_w", cur_o[0], 2);
    chk("down3_s", cur_o[1], 3);
    press(3'b010); frame_tick();
    chk("down_end_w", cur_o[0], 3);
    chk("down_end_s", cur_o[1], 3);

    // Up and down in one frame cancel; flags are cleared at the tick.
    press(3'b100); press(3'b010); frame_tick();
    chk("both_nomove", cur_o[0], 3);
    frame_tick();
    chk("both_cleared", cur_o[0], 3);

    // Confirm on box 2 with the consumer stalled for 50 cycles.
    press(3'b100); frame_tick();
    chk("cur2", cur_o[0], 2);
    press(3'b001); frame_tick();
    for (int j = 0; j < 50; j++) begin
      btn_down = (j >= 10 && j < 13);
      vblnk_in = (j >= 20 && j < 23);
      cycle();
      chk("hold_valid", sv_o[0], 1);
      chk("hold_idx", si_o[0], 2);
    end
    sel_ready = 1'b1; cycle(); sel_ready = 1'b0;
    chk("xfer_done", sv_o[0], 0);
    frame_tick();
    chk("down_dropped", cur_o[0], 2);
    press(3'b010); frame_tick();
    chk("down_after", cur_o[0], 3);

    // Ready already high when valid rises: one-cycle transfer.
    sel_ready = 1'b1;
    press(3'b001);
    vblnk_in = 1'b0; cycle();
    vblnk_in = 1'b1; cycle();
    chk("fast_valid", sv_o[0], 1);
    chk("fast_idx", si_o[0], 3);
    vblnk_in = 1'b0; cycle();
    chk("fast_done", sv_o[0], 0);
    sel_ready = 1'b0;

    // Asynchronous reset in the middle of a confirm.
    press(3'b001); frame_tick();
    set_px(500, 100); cycle(); cycle();
    chk("pre_rst_valid", sv_o[0], 1);
    #3 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    repeat (3) @(posedge pclk);
    #1 chk_zero("held_rst");
    rst_n = 1'b1;
    model_reset();
    repeat (3) cycle();
    chk("post_rst_cur", cur_o[0], 0);
    chk("post_rst_valid", sv_o[0], 0);

    // Randomised run against the model.
    for (int n = 0; n < 15000; n++) begin
      if (n % 1000 == 0) begin
        c_bg = 12'($urandom); c_frame = 12'($urandom);
        c_hl = 12'($urandom); c_fill = 12'($urandom);
      end
      hcount_in = ($urandom_range(0, 1) == 0) ? 11'(hset[$urandom_range(0, 11)]) : 11'($urandom_range(0, 2047));
      vcount_in = ($urandom_range(0, 1) == 0) ? 11'(vset[$urandom_range(0, 15)]) : 11'($urandom_range(0, 2047));
      vsync_in  = 1'($urandom);
      hsync_in  = 1'($urandom);
      hblnk_in  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) vblnk_in = ~vblnk_in;
      if ($urandom_range(0, 29) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 29) == 0) btn_down = ~btn_down;
      if ($urandom_range(0, 59) == 0) btn_enter = ~btn_enter;
      sel_ready = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
